// File: rtl/fsm1_stim_pkg.sv
// Shared definitions for the fsm1 stimulus generator: state encoding,
// signature width and default sizing.
package fsm1_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int SIG_W      = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_HOLD_W = 4;
    localparam int DEF_REP_W  = 4;

endpackage

// File: rtl/stim_pattern_ram.sv
// Pattern store: DEPTH entries of {a, b} plus a hold count.
// Synchronous write, asynchronous read, cleared by synchronous reset.
module stim_pattern_ram #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [1:0]               wab_i,
    input  logic [HOLD_W-1:0]        whold_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [1:0]               rab_o,
    output logic [HOLD_W-1:0]        rhold_o
);

    logic [1:0]        ab_q   [DEPTH];
    logic [HOLD_W-1:0] hold_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ab_q[i]   <= '0;
                hold_q[i] <= '0;
            end
        end else if (we_i) begin
            ab_q[waddr_i]   <= wab_i;
            hold_q[waddr_i] <= whold_i;
        end
    end

    assign rab_o   = ab_q[raddr_i];
    assign rhold_o = hold_q[raddr_i];

endmodule

// File: rtl/fsm1_stim_gen.sv
// Replays a programmed {a, b} sequence with per-step hold counts, repeated
// reps times, and folds the FSM-under-test's y0/y1 into a rotating signature.
module fsm1_stim_gen
    import fsm1_stim_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [1:0]               load_ab,
    input  logic [HOLD_W-1:0]        load_hold,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_steps,
    input  logic [REP_W-1:0]         reps,
    input  logic                     y0,
    input  logic                     y1,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic [SIG_W-1:0]         sig,
    output state_e                   dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       DEPTH_V  = DEPTH[AW:0];
    localparam logic [AW:0]       ONE_N    = {{AW{1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] ONE_H    = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0]  ONE_R    = {{(REP_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [AW-1:0]      step_q, step_d;
    logic [REP_W-1:0]   pass_q, pass_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic [AW:0]        nsteps_q, nsteps_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               a_q, a_d, b_q, b_d;

    logic [AW-1:0]      rd_addr;
    logic [1:0]         rd_ab;
    logic [HOLD_W-1:0]  rd_hold;
    logic [HOLD_W-1:0]  rd_hold_min1;
    logic               ram_we;
    logic               start_ok;
    logic               last_step;
    logic               more_passes;
    logic [AW-1:0]      next_step;
    logic [AW:0]        last_idx;
    logic [REP_W:0]     pass_inc;

    // Loads are locked out while a run is reading the table.
    assign ram_we = load_en && (state_q != RUN);

    stim_pattern_ram #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we),
        .waddr_i (load_addr),
        .wab_i   (load_ab),
        .whold_i (load_hold),
        .raddr_i (rd_addr),
        .rab_o   (rd_ab),
        .rhold_o (rd_hold)
    );

    assign rd_hold_min1 = (rd_hold == '0) ? ONE_H : rd_hold;
    assign last_idx     = nsteps_q - ONE_N;
    assign last_step    = ({1'b0, step_q} == last_idx);
    assign next_step    = last_step ? '0 : step_q + 1'b1;
    assign pass_inc     = {1'b0, pass_q} + {{REP_W{1'b0}}, 1'b1};
    assign more_passes  = pass_inc < {1'b0, reps_q};
    assign start_ok     = (state_q != RUN) && start && !load_en && (num_steps != '0);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        pass_d   = pass_q;
        reps_d   = reps_q;
        nsteps_d = nsteps_q;
        hold_d   = hold_q;
        sig_d    = sig_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_addr  = '0;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                if (start_ok) begin
                    state_d    = RUN;
                    nsteps_d   = (num_steps > DEPTH_V) ? DEPTH_V : num_steps;
                    reps_d     = (reps == '0) ? ONE_R : reps;
                    step_d     = '0;
                    pass_d     = '0;
                    sig_d      = '0;
                    hold_d     = rd_hold_min1;
                    {a_d, b_d} = rd_ab;
                end
            end
            RUN: begin
                sig_d   = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ {{(SIG_W-2){1'b0}}, y1, y0};
                rd_addr = next_step;
                if (hold_q <= ONE_H) begin
                    // Hold expired: next step, next pass, or finish.
                    if (!last_step || more_passes) begin
                        step_d     = next_step;
                        hold_d     = rd_hold_min1;
                        {a_d, b_d} = rd_ab;
                        if (last_step) pass_d = pass_inc[REP_W-1:0];
                    end else begin
                        state_d = FIN;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end
                end else begin
                    hold_d = hold_q - ONE_H;
                end
            end
            default: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            pass_q   <= '0;
            reps_q   <= '0;
            nsteps_q <= '0;
            hold_q   <= '0;
            sig_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            pass_q   <= pass_d;
            reps_q   <= reps_d;
            nsteps_q <= nsteps_d;
            hold_q   <= hold_d;
            sig_q    <= sig_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
    assign step_idx  = step_q;
    assign sig       = sig_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fsm1_stim_gen.sv
// Directed and randomized checks of fsm1_stim_gen against a trace model
// built by expanding the programmed table into one expected entry per cycle.
module tb_fsm1_stim_gen;
    import fsm1_stim_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [2:0] load_addr;
    logic [1:0] load_ab;
    logic [3:0] load_hold;
    logic       start;
    logic [3:0] num_steps;
    logic [3:0] reps;
    logic       y0, y1;
    logic       a, b, busy, done;
    logic [2:0] step_idx;
    logic [7:0] sig;
    state_e     dbg_state;

    fsm1_stim_gen dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_ab   (load_ab),
        .load_hold (load_hold),
        .start     (start),
        .num_steps (num_steps),
        .reps      (reps),
        .y0        (y0),
        .y1        (y1),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .sig       (sig),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_ab   [DEPTH];
    int         exp_hold [DEPTH];
    logic [W-1:0] exp_q[$];
    bit         y_const  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
    endtask

    // Called at a negedge; returns at the next negedge with the model updated.
    task automatic load(input int addr, input logic [1:0] ab, input int hold);
        load_en   = 1'b1;
        load_addr = addr[2:0];
        load_ab   = ab;
        load_hold = hold[3:0];
        exp_ab[addr]   = ab;
        exp_hold[addr] = hold;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Called at a negedge in IDLE or FIN; returns at the negedge of the FIN cycle.
    task automatic do_run(input int ns, input int rp, input bit inj_start, input bit inj_load);
        int         ns_c;
        int         rp_c;
        int         i;
        logic [7:0] msig;
        logic [W-1:0] e;
        ns_c = (ns > DEPTH) ? DEPTH : ns;
        rp_c = (rp == 0) ? 1 : rp;
        exp_q.delete();
        for (int p = 0; p < rp_c; p++)
            for (int s = 0; s < ns_c; s++)
                for (int h = 0; h < ((exp_hold[s] == 0) ? 1 : exp_hold[s]); h++)
                    exp_q.push_back({s[2:0], exp_ab[s]});
        start     = 1'b1;
        num_steps = ns[3:0];
        reps      = rp[3:0];
        @(negedge clk);
        start = 1'b0;
        msig  = 8'h00;
        i     = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_ab", {a, b}, e[1:0]);
            chk("run_step", step_idx, e[4:2]);
            chk("run_sig", sig, msig);
            y0 = y_const ? 1'b1 : 1'($urandom_range(0, 1));
            y1 = y_const ? 1'b0 : 1'($urandom_range(0, 1));
            msig = {msig[6:0], msig[7]} ^ {6'b0, y1, y0};
            start     = inj_start && (i == 1);
            load_en   = inj_load && (i == 1);
            load_addr = 3'd0;
            load_ab   = ~exp_ab[0];
            load_hold = 4'd5;
            @(negedge clk);
            start   = 1'b0;
            load_en = 1'b0;
            i++;
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_ab", {a, b}, 2'b00);
        chk("fin_sig", sig, msig);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_ab = '0; load_hold = '0;
        start = 1'b0; num_steps = '0; reps = '0; y0 = 1'b0; y1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin exp_ab[i] = 2'b00; exp_hold[i] = 0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("rst");
        chk("rst_step", step_idx, 0);
        chk("rst_sig", sig, 0);
        chk("rst_state", dbg_state, 0);

        // Basic sequence, then repeat-and-wrap.
        load(0, 2'b00, 1);
        load(1, 2'b11, 2);
        load(2, 2'b10, 1);
        do_run(3, 1, 0, 0);
        @(negedge clk);
        chk_idle("post_basic");
        do_run(3, 2, 0, 0);
        @(negedge clk);
        chk_idle("post_rep");

        // Constant y0=1, y1=0 over a three-cycle run.
        y_const = 1'b1;
        do_run(2, 1, 0, 0);
        y_const = 1'b0;
        // Start during FIN chains straight into a new run.
        do_run(3, 1, 0, 0);
        @(negedge clk);
        chk_idle("post_chain");

        // start and load_en during RUN are ignored; table checked by the next run.
        do_run(3, 1, 1, 1);
        @(negedge clk);
        do_run(3, 1, 0, 0);
        @(negedge clk);

        // load_en with start in IDLE: load wins, no run.
        start     = 1'b1;
        num_steps = 4'd3;
        reps      = 4'd1;
        load(1, 2'b01, 3);
        start = 1'b0;
        chk_idle("ldst1");
        @(negedge clk);
        chk_idle("ldst2");
        do_run(3, 1, 0, 0);
        @(negedge clk);

        // num_steps = 0 is ignored.
        start     = 1'b1;
        num_steps = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk_idle("ns0_1");
        @(negedge clk);
        chk_idle("ns0_2");

        // Zero holds, reps = 0, num_steps clamped to DEPTH.
        for (int i = 0; i < DEPTH; i++) load(i, 2'($urandom_range(0, 3)), 0);
        do_run(15, 0, 0, 0);
        @(negedge clk);

        // Randomized tables and run shapes.
        repeat (8) begin
            for (int i = 0; i < DEPTH; i++)
                load(i, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
            do_run($urandom_range(1, 10), $urandom_range(0, 3), 0, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        // Reset for two cycles mid-run at step 1.
        load(0, 2'b00, 1);
        load(1, 2'b11, 2);
        load(2, 2'b10, 1);
        start     = 1'b1;
        num_steps = 4'd3;
        reps      = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_step", step_idx, 1);
        chk("mid_ab", {a, b}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        chk("rst1_done", done, 0);
        @(negedge clk);
        chk("rst2_done", done, 0);
        reset = 1'b0;
        chk_idle("mrst");
        chk("mrst_step", step_idx, 0);
        chk("mrst_sig", sig, 0);
        @(negedge clk);
        chk("mrst_nodone", done, 0);
        for (int i = 0; i < DEPTH; i++) begin exp_ab[i] = 2'b00; exp_hold[i] = 0; end
        do_run(4, 1, 0, 0);
        @(negedge clk);
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
